// File: rtl/jtag_stream_feeder_pkg.sv
// Shared definitions for the JTAG stream feeder: FSM states, status bit
// positions and the default WAIT_EOF timeout.
package jtag_stream_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_WAIT_EOF = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam int STAT_ERR   = 0;
  localparam int STAT_ABORT = 1;
  localparam int STAT_TMO   = 2;

  localparam int DEFAULT_TIMEOUT_CYCLES = 50_000_000;

endpackage

// File: rtl/jtag_stream_feeder_unpacker.sv
// Holds one 32-bit program word and presents it a byte at a time,
// most significant byte first, stepping on each accepted write.
module word_to_byte_unpacker
  import jtag_stream_feeder_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        load_in,
  input  logic [31:0] word_in,
  input  logic        advance_in,
  output logic [7:0]  byte_out,
  output logic [1:0]  idx_out
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;

  // Next word/index: a load restarts at byte 0, a write steps to the next byte.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (load_in) begin
      word_d = word_in;
      idx_d  = 2'd0;
    end else if (advance_in) begin
      idx_d = idx_q + 2'd1;
    end
  end

  // Word and index registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  // Byte select: index 0 is bits [31:24], index 3 is bits [7:0].
  always_comb begin
    byte_out = word_q[31:24];
    case (idx_q)
      2'd0:    byte_out = word_q[31:24];
      2'd1:    byte_out = word_q[23:16];
      2'd2:    byte_out = word_q[15:8];
      default: byte_out = word_q[7:0];
    endcase
  end

  assign idx_out = idx_q;

endmodule

// File: rtl/jtag_stream_feeder.sv
// Feeds host program words into the JTAG player FIFO as bytes, counts them
// against the program length, then waits for the player to finish.
module jtag_stream_feeder
  import jtag_stream_feeder_pkg::*;
#(
  parameter int LEN_W          = 24,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             abort_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic [31:0]      word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic [7:0]       data_out,
  output logic             wr_en_out,
  input  logic             full_fifo,
  input  logic             eof_in,
  input  logic             error_in,
  output logic             busy,
  output logic             done,
  output logic [2:0]       status,
  output logic [LEN_W-1:0] bytes_sent
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] bytes_q, bytes_d;
  logic [LEN_W-1:0] bytes_inc;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [2:0]       status_q, status_d;
  logic             done_q, done_d;
  logic             accept;
  logic             load_word;
  logic [1:0]       byte_idx;

  assign busy       = (state_q == ST_FETCH) || (state_q == ST_SHIFT) ||
                      (state_q == ST_WAIT_EOF);
  assign word_ready = (state_q == ST_FETCH);
  assign accept     = word_valid && word_ready;
  // A word taken in the same cycle as an abort/error is dropped with the program.
  assign load_word  = accept && !abort_in && !error_in;
  // No write in a cycle that terminates the program.
  assign wr_en_out  = (state_q == ST_SHIFT) && !full_fifo && !abort_in && !error_in;
  assign bytes_inc  = bytes_q + LEN_W'(1);

  word_to_byte_unpacker u_unpacker (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .load_in    (load_word),
    .word_in    (word_in),
    .advance_in (wr_en_out),
    .byte_out   (data_out),
    .idx_out    (byte_idx)
  );

  // Program FSM: next state, length/byte counting, timeout and sticky status.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    bytes_d  = bytes_q;
    status_d = status_q;
    done_d   = 1'b0;
    tmo_d    = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_in) begin
          status_d = '0;
          bytes_d  = '0;
          len_d    = len_in;
          if (len_in == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (accept) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (wr_en_out && (bytes_q != len_q)) begin
          bytes_d = bytes_inc;
          if (bytes_inc == len_q)   state_d = ST_WAIT_EOF;
          else if (byte_idx == 2'd3) state_d = ST_FETCH;
        end
      end
      ST_WAIT_EOF: begin
        if (eof_in) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          status_d[STAT_TMO] = 1'b1;
          state_d            = ST_DONE;
          done_d             = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Player error and host abort terminate any running program.
    if (busy && (error_in || abort_in)) begin
      if (error_in) status_d[STAT_ERR]   = 1'b1;
      if (abort_in) status_d[STAT_ABORT] = 1'b1;
      state_d = ST_DONE;
      done_d  = 1'b1;
    end
  end

  // FSM and counter registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      bytes_q  <= '0;
      tmo_q    <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      bytes_q  <= bytes_d;
      tmo_q    <= tmo_d;
      status_q <= status_d;
      done_q   <= done_d;
    end
  end

  assign done       = done_q;
  assign status     = status_q;
  assign bytes_sent = bytes_q;

endmodule

// File: tb/tb_jtag_stream_feeder.sv
// Directed bench for jtag_stream_feeder with a short WAIT_EOF timeout.
module tb_jtag_stream_feeder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in, abort_in;
  logic [23:0] len_in;
  logic [31:0] word_in;
  logic        word_valid, word_ready;
  logic [7:0]  data_out;
  logic        wr_en_out, full_fifo, eof_in, error_in;
  logic        busy, done;
  logic [2:0]  status;
  logic [23:0] bytes_sent;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] words[$];
  logic [7:0]  got[$];
  int          widx;
  int          accepts;

  always #5 clk_in = ~clk_in;

  jtag_stream_feeder #(.LEN_W(24), .TIMEOUT_CYCLES(100)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .start_in   (start_in),
    .abort_in   (abort_in),
    .len_in     (len_in),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .data_out   (data_out),
    .wr_en_out  (wr_en_out),
    .full_fifo  (full_fifo),
    .eof_in     (eof_in),
    .error_in   (error_in),
    .busy       (busy),
    .done       (done),
    .status     (status),
    .bytes_sent (bytes_sent)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    word_valid = (widx < words.size());
    word_in    = word_valid ? words[widx] : 32'h0;
  endtask

  task automatic new_program();
    words.delete();
    got.delete();
    widx    = 0;
    accepts = 0;
  endtask

  // One clock: record what the coming edge writes/accepts, then advance to the next negedge.
  task automatic tick();
    #1;
    if (wr_en_out) got.push_back(data_out);
    if (word_valid && word_ready) begin
      widx++;
      accepts++;
    end
    @(negedge clk_in);
    refresh();
  endtask

  task automatic start(input logic [23:0] len);
    len_in   = len;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic run_to(input int n, input int bound, input string tag);
    for (int i = 0; i < bound; i++) begin
      if (got.size() >= n) break;
      tick();
    end
    chk(tag, got.size(), n);
  endtask

  task automatic finish_eof();
    eof_in = 1'b1;
    tick();
    eof_in = 1'b0;
  endtask

  initial begin
    logic [7:0] exp1 [8];
    logic [7:0] exp2 [6];
    logic [7:0] exp3 [4];
    int         cnt;
    exp1 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h11, 8'h22, 8'h33, 8'h44};
    exp2 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
    exp3 = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};

    rst_in = 1'b1; start_in = 1'b0; abort_in = 1'b0; len_in = '0;
    full_fifo = 1'b0; eof_in = 1'b0; error_in = 1'b0;
    new_program();
    refresh();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    chk("rst_bytes", bytes_sent, 0);
    chk("rst_wr_en", wr_en_out, 0);
    chk("rst_ready", word_ready, 0);
    chk("rst_data", data_out, 0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Two full words, eof after 10 cycles.
    new_program();
    words.push_back(32'hA1B2C3D4); words.push_back(32'h11223344);
    refresh();
    start(24'd8);
    chk("t1_busy", busy, 1);
    run_to(8, 40, "t1_count");
    for (int i = 0; i < 8; i++) chk($sformatf("t1_byte%0d", i), got[i], exp1[i]);
    chk("t1_bytes_sent", bytes_sent, 8);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) cnt++;
    end
    chk("t1_no_early_done", cnt, 0);
    chk("t1_still_busy", busy, 1);
    chk("t1_no_extra_wr", got.size(), 8);
    finish_eof();
    chk("t1_done", done, 1);
    chk("t1_status", status, 0);
    chk("t1_idle", busy, 0);
    tick();
    chk("t1_done_pulse", done, 0);

    // Partial last word; a third queued word must not be taken.
    new_program();
    words.push_back(32'hDEADBEEF); words.push_back(32'h0102FFFF);
    words.push_back(32'h55555555);
    refresh();
    start(24'd6);
    run_to(6, 40, "t2_count");
    for (int i = 0; i < 6; i++) chk($sformatf("t2_byte%0d", i), got[i], exp2[i]);
    chk("t2_bytes_sent", bytes_sent, 6);
    repeat (5) tick();
    chk("t2_no_extra_wr", got.size(), 6);
    chk("t2_accepts", accepts, 2);
    chk("t2_ready", word_ready, 0);
    finish_eof();
    chk("t2_done", done, 1);

    // FIFO full stall after the first byte.
    new_program();
    words.push_back(32'hCAFEF00D);
    refresh();
    start(24'd4);
    run_to(1, 20, "t3_first");
    full_fifo = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (wr_en_out) cnt++;
      tick();
    end
    chk("t3_wr_while_full", cnt, 0);
    chk("t3_held_count", got.size(), 1);
    chk("t3_held_bytes", bytes_sent, 1);
    full_fifo = 1'b0;
    run_to(4, 20, "t3_count");
    for (int i = 0; i < 4; i++) chk($sformatf("t3_byte%0d", i), got[i], exp3[i]);
    chk("t3_bytes_sent", bytes_sent, 4);
    finish_eof();
    chk("t3_status", status, 0);

    // Player error after 3 of 12 bytes.
    new_program();
    words.push_back(32'h01020304); words.push_back(32'h05060708);
    words.push_back(32'h090A0B0C);
    refresh();
    start(24'd12);
    run_to(3, 20, "t4_first3");
    error_in = 1'b1;
    tick();
    error_in = 1'b0;
    chk("t4_done", done, 1);
    chk("t4_status", status, 3'b001);
    chk("t4_idle", busy, 0);
    chk("t4_ready", word_ready, 0);
    repeat (5) tick();
    chk("t4_no_more_wr", got.size(), 3);
    chk("t4_accepts", accepts, 1);
    chk("t4_bytes_sent", bytes_sent, 3);

    // No eof: timeout 100 cycles after entering WAIT_EOF.
    new_program();
    words.push_back(32'h0BADF00D);
    refresh();
    start(24'd4);
    run_to(4, 20, "t5_count");
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      cnt++;
      if (done) break;
    end
    chk("t5_tmo_cycles", cnt, 100);
    chk("t5_status", status, 3'b100);
    chk("t5_idle", busy, 0);

    // Abort during SHIFT, then a zero-length start.
    new_program();
    words.push_back(32'h76543210); words.push_back(32'hFEDCBA98);
    refresh();
    start(24'd8);
    run_to(2, 20, "t6_first2");
    abort_in = 1'b1;
    #1;
    chk("t6_wr_in_abort", wr_en_out, 0);
    tick();
    abort_in = 1'b0;
    chk("t6_done", done, 1);
    chk("t6_status", status, 3'b010);
    chk("t6_count", got.size(), 2);
    chk("t6_bytes_sent", bytes_sent, 2);
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    chk("t6_idle_abort_status", status, 3'b010);
    chk("t6_idle_abort_done", done, 0);
    start(24'd0);
    chk("t6_len0_done", done, 1);
    chk("t6_len0_status", status, 0);
    chk("t6_len0_busy", busy, 0);
    chk("t6_len0_bytes", bytes_sent, 0);
    tick();
    chk("t6_len0_pulse", done, 0);

    // Asynchronous reset mid-program.
    new_program();
    words.push_back(32'h13579BDF); words.push_back(32'h2468ACE0);
    refresh();
    start(24'd8);
    run_to(3, 20, "t7_first3");
    rst_in = 1'b1;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_bytes", bytes_sent, 0);
    chk("t7_ready", word_ready, 0);
    chk("t7_data", data_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("t7_stays_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
